// File: rtl/ceres_pbus_bridge_pkg.sv
// Shared types and constants for the peripheral-bus bridge.
// Slot map: UART0, UART1, SPI0, I2C0, GPIO, PWM, Timer, PLIC in 4 KB slots.
package ceres_pbus_bridge_pkg;

  localparam int unsigned PBUS_ADDR_W    = 32;
  localparam int unsigned PBUS_LINE_W    = 128;
  localparam int unsigned PBUS_WORD_W    = 32;
  localparam int unsigned PBUS_STRB_W    = 4;
  localparam int unsigned PBUS_LANES     = 4;
  localparam int unsigned PBUS_OFF_W     = 12;
  localparam int unsigned PBUS_SLOT_W    = 4;
  localparam int unsigned PBUS_MAX_SLOTS = 16;

  localparam logic [PBUS_SLOT_W-1:0] PBUS_UART0 = 4'd0;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_UART1 = 4'd1;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_SPI0  = 4'd2;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_I2C0  = 4'd3;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_GPIO  = 4'd4;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_PWM   = 4'd5;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_TIMER = 4'd6;
  localparam logic [PBUS_SLOT_W-1:0] PBUS_PLIC  = 4'd7;

  typedef enum logic [1:0] {
    PBUS_IDLE   = 2'd0,
    PBUS_SETUP  = 2'd1,
    PBUS_ACCESS = 2'd2,
    PBUS_RESP   = 2'd3
  } pbus_state_e;

  // APB command latched at accept and held through SETUP/ACCESS
  typedef struct packed {
    logic                   write;
    logic [PBUS_OFF_W-1:0]  addr;
    logic [PBUS_WORD_W-1:0] wdata;
    logic [PBUS_STRB_W-1:0] strb;
  } pbus_apb_cmd_t;

  function automatic logic [PBUS_SLOT_W-1:0] pbus_slot(input logic [PBUS_ADDR_W-1:0] addr);
    return addr[15:12];
  endfunction

endpackage

// File: rtl/ceres_pbus_bridge_if.sv
// CPU request/response and APB slot signals of the peripheral-bus bridge.
// slave = bridge side, master = CPU wrapper plus peripheral slots.
interface ceres_pbus_bridge_if #(
  parameter int unsigned NUM_SLOTS = 8
) ();
  import ceres_pbus_bridge_pkg::*;

  logic                             req_valid_i;
  logic                             req_sel_i;
  logic [PBUS_ADDR_W-1:0]           req_addr_i;
  logic [PBUS_LINE_W-1:0]           req_data_i;
  logic [PBUS_LINE_W/8-1:0]         req_rw_i;
  logic                             res_valid_o;
  logic [PBUS_LINE_W-1:0]           res_data_o;
  logic [NUM_SLOTS-1:0]             psel_o;
  logic                             penable_o;
  logic                             pwrite_o;
  logic [PBUS_OFF_W-1:0]            paddr_o;
  logic [PBUS_WORD_W-1:0]           pwdata_o;
  logic [PBUS_STRB_W-1:0]           pstrb_o;
  logic [NUM_SLOTS*PBUS_WORD_W-1:0] prdata_i;
  logic [NUM_SLOTS-1:0]             pready_i;
  logic [NUM_SLOTS-1:0]             pslverr_i;
  logic                             bus_err_o;
  logic [PBUS_ADDR_W-1:0]           err_addr_o;

  modport slave (
    input  req_valid_i, req_sel_i, req_addr_i, req_data_i, req_rw_i,
    input  prdata_i, pready_i, pslverr_i,
    output res_valid_o, res_data_o, psel_o, penable_o, pwrite_o,
    output paddr_o, pwdata_o, pstrb_o, bus_err_o, err_addr_o
  );

  modport master (
    output req_valid_i, req_sel_i, req_addr_i, req_data_i, req_rw_i,
    output prdata_i, pready_i, pslverr_i,
    input  res_valid_o, res_data_o, psel_o, penable_o, pwrite_o,
    input  paddr_o, pwdata_o, pstrb_o, bus_err_o, err_addr_o
  );

endinterface

// File: rtl/ceres_pbus_bridge.sv
// CPU uncached request -> APB single-word transfer bridge with slot decode.
// Optional ACCESS timeout enabled by defining CERES_PBUS_TIMEOUT_EN.
module ceres_pbus_bridge
  import ceres_pbus_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk_i,
  input logic                rst_ni,
  ceres_pbus_bridge_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'(PBUS_IDLE);
  localparam logic [1:0] ST_SETUP  = 2'(PBUS_SETUP);
  localparam logic [1:0] ST_ACCESS = 2'(PBUS_ACCESS);
  localparam logic [1:0] ST_RESP   = 2'(PBUS_RESP);

  // An illegal configuration decodes nothing, so every request errors out
  localparam bit CFG_OK = (NUM_SLOTS >= 1) && (NUM_SLOTS <= PBUS_MAX_SLOTS) &&
                          (TIMEOUT_CYCLES >= 1);

  logic [1:0]             state_q, state_d;
  logic [PBUS_ADDR_W-1:0] addr_q, addr_d;
  logic                   is_write_q, is_write_d;
  pbus_apb_cmd_t          cmd_q, cmd_d;
  logic [NUM_SLOTS-1:0]   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   res_valid_q, res_valid_d;
  logic [PBUS_LINE_W-1:0] res_data_q, res_data_d;
  logic                   bus_err_q, bus_err_d;
  logic [PBUS_ADDR_W-1:0] err_addr_q, err_addr_d;

`ifdef CERES_PBUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = (32'(tmo_q) + 32'd1) >= TIMEOUT_CYCLES;
`endif

  logic                   accept;
  logic                   req_unmapped;
  logic [PBUS_SLOT_W-1:0] req_slot;
  logic [1:0]             lane;
  logic [PBUS_STRB_W-1:0] lane_strb;
  logic [PBUS_WORD_W-1:0] lane_data;
  logic [PBUS_WORD_W-1:0] sel_rdata;
  logic                   sel_ready;
  logic                   sel_err;

  // Request decode: slot, mapping and the 32-bit lane picked by addr[3:2]
  always_comb begin
    accept       = bus.req_valid_i & bus.req_sel_i;
    req_slot     = pbus_slot(bus.req_addr_i);
    req_unmapped = (|bus.req_addr_i[23:16]) || (32'(req_slot) >= NUM_SLOTS) || !CFG_OK;
    lane         = bus.req_addr_i[3:2];
    lane_strb    = bus.req_rw_i[{lane, 2'b00} +: PBUS_STRB_W];
    lane_data    = bus.req_data_i[{lane, 5'b00000} +: PBUS_WORD_W];
  end

  // Only the addressed slot's ready/error/data are ever looked at
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (pbus_slot(addr_q) == PBUS_SLOT_W'(i)) begin
        sel_rdata = bus.prdata_i[i*PBUS_WORD_W +: PBUS_WORD_W];
        sel_ready = bus.pready_i[i];
        sel_err   = bus.pslverr_i[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    is_write_d  = is_write_q;
    cmd_d       = cmd_q;
    res_valid_d = 1'b0;
    res_data_d  = '0;
    bus_err_d   = 1'b0;
    err_addr_d  = err_addr_q;
    psel_d      = '0;
`ifdef CERES_PBUS_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d     = bus.req_addr_i;
          is_write_d = |bus.req_rw_i;
          if (req_unmapped) begin
            state_d     = ST_RESP;
            res_valid_d = 1'b1;
            bus_err_d   = 1'b1;
            err_addr_d  = bus.req_addr_i;
          end else begin
            state_d     = ST_SETUP;
            cmd_d.write = |lane_strb;
            cmd_d.addr  = {bus.req_addr_i[PBUS_OFF_W-1:2], 2'b00};
            cmd_d.wdata = lane_data;
            cmd_d.strb  = lane_strb;
`ifdef CERES_PBUS_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d     = ST_RESP;
          res_valid_d = 1'b1;
          if (sel_err) begin
            bus_err_d  = 1'b1;
            err_addr_d = addr_q;
          end else if (!is_write_q) begin
            res_data_d = {PBUS_LANES{sel_rdata}};
          end
        end
`ifdef CERES_PBUS_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d     = ST_RESP;
          res_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          err_addr_d  = addr_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        psel_d[i] = (pbus_slot(addr_d) == PBUS_SLOT_W'(i));
      end
    end
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      is_write_q  <= 1'b0;
      cmd_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
`ifdef CERES_PBUS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      is_write_q  <= is_write_d;
      cmd_q       <= cmd_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
`ifdef CERES_PBUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = cmd_q.write;
  assign bus.paddr_o     = cmd_q.addr;
  assign bus.pwdata_o    = cmd_q.wdata;
  assign bus.pstrb_o     = cmd_q.strb;
  assign bus.bus_err_o   = bus_err_q;
  assign bus.err_addr_o  = err_addr_q;

endmodule
